// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite response codes and the register-window address decode.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } dec_t;

    // Low address bits below the word size are ignored; addresses below base miss.
    function automatic dec_t addr_decode(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned num_regs,
                                         input int unsigned data_w);
        dec_t        d;
        logic [31:0] off;
        off   = addr - base;
        d.idx = (data_w == 64) ? (off >> 3) : (off >> 2);
        d.hit = (addr >= base) && (d.idx < num_regs);
        return d;
    endfunction

endpackage

// File: rtl/axi4l_slv_regs_if.sv
// AXI4-Lite channel bundle between a bench master and the register slave.
interface axi4l_slv_regs_if #(
    parameter int DATA_W = 32
);
    logic [31:0]         s_axi_awaddr;
    logic [2:0]          s_axi_awprot;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [31:0]         s_axi_araddr;
    logic [2:0]          s_axi_arprot;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axi4l_regfile.sv
// Byte-strobed register storage with one write port, a combinational read
// port and the whole array exposed flat.
module axi4l_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                                               axi_aclk,
    input  logic                                               axi_aresetn,
    input  logic                                               i_we,
    input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] i_idx,
    input  logic [DATA_W-1:0]                                  i_wdata,
    input  logic [DATA_W/8-1:0]                                i_wstrb,
    input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] i_rd_idx,
    output logic [DATA_W-1:0]                                  o_rd_data,
    output logic [NUM_REGS*DATA_W-1:0]                         o_reg_q
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_idx == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (i_wstrb[b]) r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Index values past NUM_REGS-1 read as zero rather than aliasing.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: rtl/axi4l_slv_regs.sv
// AXI4-Lite slave with real register storage: independent AW/W capture,
// DECERR for out-of-window addresses and a programmable read latency.
module axi4l_slv_regs
    import axi4l_pkg::*;
#(
    parameter string       INST_NAME = "u_axi4l_slv_regs",
    parameter int          DATA_W    = 32,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_LAT    = 0,
    parameter int          LOG_EN    = 1
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    axi4l_slv_regs_if.slave            s_axi,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "%s: DATA_W must be 32 or 64", INST_NAME);
    end
    if (NUM_REGS < 1) begin : g_bad_num_regs
        $fatal(1, "%s: NUM_REGS must be at least 1", INST_NAME);
    end
    if (RD_LAT < 0 || RD_LAT > 15) begin : g_bad_rd_lat
        $fatal(1, "%s: RD_LAT must be 0..15", INST_NAME);
    end
    if ((BASE_ADDR & 32'(STRB_W - 1)) != 32'd0) begin : g_bad_base
        $fatal(1, "%s: BASE_ADDR not aligned to the register width", INST_NAME);
    end

    logic              r_ready_en;
    logic              r_aw_held, r_w_held, r_ar_held;
    logic [31:0]       r_aw_addr, r_ar_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid, r_rvalid;
    resp_e             r_bresp, r_rresp;
    logic [3:0]        r_rd_cnt;

    logic              w_awready, w_wready, w_arready;
    logic              w_aw_hs, w_w_hs, w_ar_hs;
    logic              w_commit, w_rd_fire;
    dec_t              w_wr_dec, w_rd_dec;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused;

    assign w_unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot};

    assign w_wr_dec  = addr_decode(r_aw_addr, BASE_ADDR, NUM_REGS, DATA_W);
    assign w_rd_dec  = addr_decode(r_ar_addr, BASE_ADDR, NUM_REGS, DATA_W);

    assign w_awready = r_ready_en & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_ready_en & ~r_w_held & ~r_bvalid;
    assign w_arready = r_ready_en & ~r_ar_held & ~r_rvalid;
    assign w_aw_hs   = s_axi.s_axi_awvalid & w_awready;
    assign w_w_hs    = s_axi.s_axi_wvalid & w_wready;
    assign w_ar_hs   = s_axi.s_axi_arvalid & w_arready;
    assign w_commit  = r_aw_held & r_w_held;
    assign w_rd_fire = r_ar_held & (r_rd_cnt == 4'd0);

    // Async assert, release lands on the first clock edge after reset lifts.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_ready_en <= 1'b0;
        else              r_ready_en <= 1'b1;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi.s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.s_axi_wdata;
                r_wstrb  <= s_axi.s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_dec.hit ? OKAY : DECERR;
            end else if (r_bvalid && s_axi.s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_ar_held <= 1'b0;
            r_ar_addr <= '0;
            r_rd_cnt  <= '0;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ar_held <= 1'b1;
                r_ar_addr <= s_axi.s_axi_araddr;
                r_rd_cnt  <= 4'(RD_LAT);
            end else if (w_rd_fire) begin
                r_ar_held <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rresp   <= w_rd_dec.hit ? OKAY : DECERR;
                r_rdata   <= w_rd_dec.hit ? w_rd_data : '0;
            end else if (r_ar_held) begin
                r_rd_cnt <= r_rd_cnt - 4'd1;
            end
            if (r_rvalid && s_axi.s_axi_rready) r_rvalid <= 1'b0;
        end
    end

    // Read port samples pre-edge storage, so a same-edge commit is not visible.
    axi4l_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .i_we        (w_commit & w_wr_dec.hit),
        .i_idx       (IDX_W'(w_wr_dec.idx)),
        .i_wdata     (r_wdata),
        .i_wstrb     (r_wstrb),
        .i_rd_idx    (IDX_W'(w_rd_dec.idx)),
        .o_rd_data   (w_rd_data),
        .o_reg_q     (reg_q)
    );

    assign s_axi.s_axi_awready = w_awready;
    assign s_axi.s_axi_wready  = w_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rresp   = r_rresp;
    assign s_axi.s_axi_rdata   = r_rdata;

    always @(posedge axi_aclk) begin
        if (LOG_EN != 0 && axi_aresetn) begin
            if (w_commit)
                $strobe("%t: [%s] WR ( ADDR=%h, DATA=%h, STRB=%h, RESP=%h )",
                        $time, INST_NAME, r_aw_addr, r_wdata, r_wstrb, r_bresp);
            if (w_rd_fire && !w_ar_hs)
                $strobe("%t: [%s] RD ( ADDR=%h, DATA=%h, RESP=%h )",
                        $time, INST_NAME, r_ar_addr, r_rdata, r_rresp);
        end
    end

endmodule

// File: tb/tb_axi4l_slv_regs.sv
// Directed bench for axi4l_slv_regs: strobed writes, split AW/W, read latency,
// DECERR window, same-edge write/read ordering and mid-transaction reset.
module tb_axi4l_slv_regs;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int RD_LAT   = 3;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS*DATA_W-1:0] exp_q;
    int                         checks = 0;
    int                         failures = 0;
    logic [1:0]                 resp;
    logic [31:0]                rdata;
    int                         nb, nr;

    axi4l_slv_regs_if #(.DATA_W(DATA_W)) bus ();

    axi4l_slv_regs #(
        .INST_NAME ("u_dut"),
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (32'h0000_0000),
        .RD_LAT    (RD_LAT),
        .LOG_EN    (1)
    ) u_dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .s_axi       (bus),
        .reg_q       (reg_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r);
        int n;
        n = 0;
        bus.s_axi_awaddr  = a;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = d;
        bus.s_axi_wstrb   = s;
        bus.s_axi_wvalid  = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        while (bus.s_axi_bvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_bvalid_timeout", 64'(bus.s_axi_bvalid), 64'h1);
        r = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        while (bus.s_axi_rvalid !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("rd_rvalid_timeout", 64'(bus.s_axi_rvalid), 64'h1);
        d = bus.s_axi_rdata;
        r = bus.s_axi_rresp;
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
    endtask

    initial begin
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awprot  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arprot  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;
        exp_q = '0;

        // Reset state and release
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(bus.s_axi_awready), 64'h0);
        chk("rst_arready", 64'(bus.s_axi_arready), 64'h0);
        chk("rst_bvalid", 64'(bus.s_axi_bvalid), 64'h0);
        chk("rst_rvalid", 64'(bus.s_axi_rvalid), 64'h0);
        chk_q("rst_reg_q", reg_q, exp_q);
        #2 rst_n = 1'b1;
        #1 chk("rel_awready_pre_edge", 64'(bus.s_axi_awready), 64'h0);
        @(negedge clk);
        chk("rel_awready", 64'(bus.s_axi_awready), 64'h1);
        chk("rel_wready", 64'(bus.s_axi_wready), 64'h1);
        chk("rel_arready", 64'(bus.s_axi_arready), 64'h1);

        // AW and W together: bvalid two edges after assertion
        bus.s_axi_awaddr  = 32'h4;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = 32'hDEADBEEF;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_wvalid  = 1'b1;
        @(negedge clk);
        chk("t1_bvalid_edge1", 64'(bus.s_axi_bvalid), 64'h0);
        chk("t1_awready_held", 64'(bus.s_axi_awready), 64'h0);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        @(negedge clk);
        exp_q[63:32] = 32'hDEADBEEF;
        chk("t1_bvalid_edge2", 64'(bus.s_axi_bvalid), 64'h1);
        chk("t1_bresp", 64'(bus.s_axi_bresp), 64'h0);
        chk_q("t1_reg_q", reg_q, exp_q);
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        chk("t1_bvalid_drop", 64'(bus.s_axi_bvalid), 64'h0);
        chk("t1_awready_back", 64'(bus.s_axi_awready), 64'h1);

        // W three cycles ahead of AW, partial strobe onto a preloaded register
        do_write(32'h8, 32'h11223344, 4'hF, resp);
        exp_q[95:64] = 32'h11223344;
        chk("t2_preload_bresp", 64'(resp), 64'h0);
        bus.s_axi_wdata  = 32'hAABBCCDD;
        bus.s_axi_wstrb  = 4'b0101;
        bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_wvalid = 1'b0;
        chk("t2_wready_held", 64'(bus.s_axi_wready), 64'h0);
        repeat (2) @(negedge clk);
        chk("t2_no_b_before_aw", 64'(bus.s_axi_bvalid), 64'h0);
        bus.s_axi_awaddr  = 32'h8;
        bus.s_axi_awvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        chk("t2_bvalid_aw_edge", 64'(bus.s_axi_bvalid), 64'h0);
        @(negedge clk);
        exp_q[95:64] = 32'h11BB33DD;
        chk("t2_bvalid", 64'(bus.s_axi_bvalid), 64'h1);
        chk("t2_bresp", 64'(bus.s_axi_bresp), 64'h0);
        chk_q("t2_reg_q", reg_q, exp_q);
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        nb = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) nb++;
        end
        chk("t2_single_b", 64'(nb), 64'h0);

        // Read with RD_LAT=3: rvalid exactly four edges after AR, held under backpressure
        bus.s_axi_araddr  = 32'h4;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        chk("t3_arready_held", 64'(bus.s_axi_arready), 64'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t3_rvalid_early", 64'(bus.s_axi_rvalid), 64'h0);
        end
        @(negedge clk);
        chk("t3_rvalid_edge4", 64'(bus.s_axi_rvalid), 64'h1);
        chk("t3_rdata", 64'(bus.s_axi_rdata), 64'hDEADBEEF);
        chk("t3_rresp", 64'(bus.s_axi_rresp), 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_rvalid_hold", 64'(bus.s_axi_rvalid), 64'h1);
            chk("t3_rdata_hold", 64'(bus.s_axi_rdata), 64'hDEADBEEF);
            chk("t3_arready_low", 64'(bus.s_axi_arready), 64'h0);
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
        chk("t3_rvalid_drop", 64'(bus.s_axi_rvalid), 64'h0);
        chk("t3_arready_back", 64'(bus.s_axi_arready), 64'h1);

        // Out-of-window access and the last in-window register
        do_write(32'h40, 32'h12345678, 4'hF, resp);
        chk("t4_wr_decerr", 64'(resp), 64'h3);
        chk_q("t4_reg_q_unchanged", reg_q, exp_q);
        do_read(32'h40, rdata, resp);
        chk("t4_rd_decerr", 64'(resp), 64'h3);
        chk("t4_rd_data_zero", 64'(rdata), 64'h0);
        do_write(32'h3C, 32'hCAFEBABE, 4'b1100, resp);
        exp_q[511:480] = 32'hCAFE0000;
        chk("t4_last_wr_okay", 64'(resp), 64'h0);
        chk_q("t4_last_reg_q", reg_q, exp_q);
        do_read(32'h3C, rdata, resp);
        chk("t4_last_rd_okay", 64'(resp), 64'h0);
        chk("t4_last_rd_data", 64'(rdata), 64'hCAFE0000);

        // Write commit on the same edge as the read sample returns the old value
        do_write(32'h4, 32'h0, 4'hF, resp);
        exp_q[63:32] = 32'h0;
        chk_q("t5_clear_reg1", reg_q, exp_q);
        bus.s_axi_araddr  = 32'h4;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        bus.s_axi_awaddr  = 32'h4;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = 32'h5;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_wvalid  = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        chk("t5_rvalid_before", 64'(bus.s_axi_rvalid), 64'h0);
        @(negedge clk);
        exp_q[63:32] = 32'h5;
        chk("t5_rvalid", 64'(bus.s_axi_rvalid), 64'h1);
        chk("t5_bvalid", 64'(bus.s_axi_bvalid), 64'h1);
        chk("t5_rdata_old", 64'(bus.s_axi_rdata), 64'h0);
        chk_q("t5_reg_q_new", reg_q, exp_q);
        bus.s_axi_bready = 1'b1;
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        bus.s_axi_rready = 1'b0;
        do_read(32'h4, rdata, resp);
        chk("t5_rdata_new", 64'(rdata), 64'h5);

        // Reset with a read counting (counter=2) and AW held
        bus.s_axi_araddr  = 32'h4;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_awaddr  = 32'h8;
        bus.s_axi_awvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_awvalid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q = '0;
        chk("t6_awready", 64'(bus.s_axi_awready), 64'h0);
        chk("t6_wready", 64'(bus.s_axi_wready), 64'h0);
        chk("t6_arready", 64'(bus.s_axi_arready), 64'h0);
        chk("t6_bvalid", 64'(bus.s_axi_bvalid), 64'h0);
        chk("t6_rvalid", 64'(bus.s_axi_rvalid), 64'h0);
        chk("t6_rdata", 64'(bus.s_axi_rdata), 64'h0);
        chk_q("t6_reg_q", reg_q, exp_q);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("t6_awready_pre_edge", 64'(bus.s_axi_awready), 64'h0);
        @(negedge clk);
        chk("t6_awready_back", 64'(bus.s_axi_awready), 64'h1);
        chk("t6_arready_back", 64'(bus.s_axi_arready), 64'h1);
        nb = 0;
        nr = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) nb++;
            if (bus.s_axi_rvalid) nr++;
        end
        chk("t6_no_b_after", 64'(nb), 64'h0);
        chk("t6_no_r_after", 64'(nr), 64'h0);
        chk_q("t6_reg_q_after", reg_q, exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
